// File: rtl/mod_n_counter.sv
// Purpose : modulo-N up counter with sync reset, parallel load and a terminal-count flag.
// Latency : cnt updates one clk edge after rst/load/en are sampled; carry is combinational.
// Backpressure: none; en=0 holds the count, there is no handshake.
// Optional feature: define MODN_LOAD_CLAMP_EN to store 0 on an out-of-range load.
module mod_n_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [4:0] data,
  input  logic [4:0] mode,
  output logic [4:0] cnt,
  output logic       carry
);

  // Terminal value is mode-1 taken modulo 32, so mode=0 gives a mod-32 counter
  // and mode=1 keeps the count pinned at 0.
  logic [4:0] term_val;
  logic       wrap;
  logic [4:0] load_val;

  assign term_val = mode - 5'd1;

  // Unsigned >= rather than == so an out-of-range count recovers on the next enabled edge.
  assign wrap  = (cnt >= term_val);
  assign carry = en & wrap;

`ifdef MODN_LOAD_CLAMP_EN
  // Out-of-range loads are folded to 0 so the count never leaves 0..N-1.
  always_comb begin
    load_val = data;
    if ((mode != 5'd0) && (data >= mode)) begin
      load_val = 5'd0;
    end
  end
`else
  // Loads are stored as-is; an out-of-range value wraps on the next enabled edge.
  always_comb begin
    load_val = data;
  end
`endif

  // Count register: rst beats load, load beats en, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 5'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= wrap ? 5'd0 : (cnt + 5'd1);
    end
  end

endmodule

// File: tb/tb_mod_n_counter.sv
module tb_mod_n_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [4:0] data;
  logic [4:0] mode;
  logic [4:0] cnt;
  logic       carry;

  int n_checks;
  int n_fail;

  mod_n_counter dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .data  (data),
    .mode  (mode),
    .cnt   (cnt),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       en;
    bit       load;
    int       data;
    int       mode;
    bit       ck_carry;
    int       exp_carry;
    int       exp_cnt;
    string    name;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addv(input bit r, input bit e, input bit l, input int d, input int m,
                      input bit ck, input int ec, input int en_cnt, input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.load = l; v.data = d; v.mode = m;
    v.ck_carry = ck; v.exp_carry = ec; v.exp_cnt = en_cnt; v.name = nm;
    vq.push_back(v);
  endtask

  // Drive inputs at negedge, check carry before the edge, check cnt after it.
  task automatic apply(input bit r, input bit e, input bit l, input int d, input int m,
                       input bit ck, input int ec, input int ecnt, input string nm);
    @(negedge clk);
    rst = r; en = e; load = l; data = d[4:0]; mode = m[4:0];
    #1;
    if (ck) check({nm, ".carry"}, int'(carry), ec);
    @(posedge clk);
    #1;
    check({nm, ".cnt"}, int'(cnt), ecnt);
  endtask

  // Reference model: counts 0..N-1 with N = 32 when mode is 0; a count at or
  // beyond the last legal value wraps to 0 on an enabled edge.
  int m_cnt;

  function automatic int modulus(input int m);
    return (m == 0) ? 32 : m;
  endfunction

  function automatic int model_carry(input int c, input bit e, input int m);
    return (e && (c >= modulus(m) - 1)) ? 1 : 0;
  endfunction

  function automatic int model_next(input int c, input bit r, input bit e, input bit l,
                                    input int d, input int m);
    if (r) return 0;
    if (l) begin
`ifdef MODN_LOAD_CLAMP_EN
      if (m != 0 && d >= m) return 0;
`endif
      return d;
    end
    if (e) return (c >= modulus(m) - 1) ? 0 : c + 1;
    return c;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; en = 1'b1; load = 1'b1; data = 5'd22; mode = 5'd6;

    // Reset dominates load and enable; carry unknown before first edge.
    addv(1, 1, 1, 22, 6, 0, 0, 0, "reset1");
    addv(1, 1, 1, 22, 6, 1, 0, 0, "reset2");
    addv(0, 0, 0, 0, 6, 1, 0, 0, "post_reset_en0");
    addv(0, 0, 0, 0, 1, 1, 0, 0, "post_reset_mode1_en0");

    // Mod-6 counting, carry only while cnt=5.
    for (int i = 0; i < 14; i++)
      addv(0, 1, 0, 0, 6, 1, ((i % 6) == 5) ? 1 : 0, (i + 1) % 6, "count6");
    addv(0, 1, 0, 0, 6, 1, 0, 3, "count6_to3");

    // Hold with en=0, then load while disabled.
    for (int i = 0; i < 10; i++)
      addv(0, 0, 0, 0, 6, 1, 0, 3, "hold");
    addv(0, 0, 1, 4, 6, 1, 0, 4, "load_en0");

    // Out-of-range load with en=1 (load wins), then recovery.
`ifdef MODN_LOAD_CLAMP_EN
    addv(0, 1, 1, 22, 6, 1, 0, 0, "oor_load");
    addv(0, 1, 0, 0, 6, 1, 0, 1, "oor_next1");
    addv(0, 1, 0, 0, 6, 1, 0, 2, "oor_next2");
`else
    addv(0, 1, 1, 22, 6, 1, 0, 22, "oor_load");
    addv(0, 1, 0, 0, 6, 1, 1, 0, "oor_wrap");
    addv(0, 1, 0, 0, 6, 1, 0, 1, "oor_next");
`endif

    // Mid-count reset together with load.
    addv(0, 0, 1, 4, 6, 1, 0, 4, "load4");
    addv(1, 1, 1, 2, 6, 1, 0, 0, "midreset");
    addv(0, 1, 0, 0, 6, 1, 0, 1, "resume1");
    addv(0, 1, 0, 0, 6, 1, 0, 2, "resume2");

    // Mode=1 keeps cnt at 0 with carry high.
    for (int i = 0; i < 3; i++)
      addv(0, 1, 0, 0, 1, 1, 1, 0, "mode1");

    // Mode change leaves cnt alone and moves the wrap point immediately.
    addv(0, 0, 1, 10, 6, 1, 0, 10, "load10");
    addv(0, 0, 0, 0, 20, 1, 0, 10, "mode_chg_hold");
    addv(0, 1, 0, 0, 20, 1, 0, 11, "mode20_count");
    addv(0, 1, 0, 0, 12, 1, 1, 0, "mode12_wrap");

    // Carry ignores load and rst.
    addv(0, 0, 1, 5, 6, 1, 0, 5, "load5");
    addv(0, 1, 1, 3, 6, 1, 1, 3, "carry_with_load");
    addv(0, 0, 1, 5, 6, 1, 0, 5, "load5b");
    addv(1, 1, 0, 0, 6, 1, 1, 0, "carry_with_rst");

    // Mode=0: full mod-32 cycle.
    for (int i = 0; i < 32; i++)
      addv(0, 1, 0, 0, 0, 1, (i == 31) ? 1 : 0, (i + 1) % 32, "mode0");

    foreach (vq[i])
      apply(vq[i].rst, vq[i].en, vq[i].load, vq[i].data, vq[i].mode,
            vq[i].ck_carry, vq[i].exp_carry, vq[i].exp_cnt, vq[i].name);

    // Randomized run against the reference model; cnt is known (0) here.
    m_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      bit r, e, l;
      int d, m, ec, nc;
      r = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      d = $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0:       m = $urandom_range(0, 1);
        default: m = $urandom_range(0, 31);
      endcase
      ec = model_carry(m_cnt, e, m);
      nc = model_next(m_cnt, r, e, l, d, m);
      apply(r, e, l, d, m, 1, ec, nc, "random");
      m_cnt = nc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
